// File: rtl/axi4_lite_rr_arbiter_2to1.sv
// axi4_lite_rr_arbiter_2to1: round-robin sharing of one AXI4-Lite slave between two masters,
// with independent write (AW/W/B) and read (AR/R) grants held until the response handshake.
module axi4_lite_rr_arbiter_2to1 #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr_i,
  input  logic                      s0_awvalid_i,
  output logic                      s0_awready_o,
  input  logic [DATA_WIDTH-1:0]     s0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb_i,
  input  logic                      s0_wvalid_i,
  output logic                      s0_wready_o,
  output logic [1:0]                s0_bresp_o,
  output logic                      s0_bvalid_o,
  input  logic                      s0_bready_i,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr_i,
  input  logic                      s0_arvalid_i,
  output logic                      s0_arready_o,
  output logic [DATA_WIDTH-1:0]     s0_rdata_o,
  output logic [1:0]                s0_rresp_o,
  output logic                      s0_rvalid_o,
  input  logic                      s0_rready_i,
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr_i,
  input  logic                      s1_awvalid_i,
  output logic                      s1_awready_o,
  input  logic [DATA_WIDTH-1:0]     s1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb_i,
  input  logic                      s1_wvalid_i,
  output logic                      s1_wready_o,
  output logic [1:0]                s1_bresp_o,
  output logic                      s1_bvalid_o,
  input  logic                      s1_bready_i,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr_i,
  input  logic                      s1_arvalid_i,
  output logic                      s1_arready_o,
  output logic [DATA_WIDTH-1:0]     s1_rdata_o,
  output logic [1:0]                s1_rresp_o,
  output logic                      s1_rvalid_o,
  input  logic                      s1_rready_i,
  output logic [ADDR_WIDTH-1:0]     m_awaddr_o,
  output logic                      m_awvalid_o,
  input  logic                      m_awready_i,
  output logic [DATA_WIDTH-1:0]     m_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_wstrb_o,
  output logic                      m_wvalid_o,
  input  logic                      m_wready_i,
  input  logic [1:0]                m_bresp_i,
  input  logic                      m_bvalid_i,
  output logic                      m_bready_o,
  output logic [ADDR_WIDTH-1:0]     m_araddr_o,
  output logic                      m_arvalid_o,
  input  logic                      m_arready_i,
  input  logic [DATA_WIDTH-1:0]     m_rdata_i,
  input  logic [1:0]                m_rresp_i,
  input  logic                      m_rvalid_i,
  output logic                      m_rready_o
);
  typedef enum logic [1:0] {W_IDLE, W_GNT0, W_GNT1} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_GNT0, R_GNT1} r_state_t;

  w_state_t w_q, w_d;
  r_state_t r_q, r_d;
  logic     last_wr_q, last_wr_d, last_rd_q, last_rd_d;
  logic     wreq0, wreq1, wg0, wg1, rg0, rg1;

  assign wreq0 = s0_awvalid_i | s0_wvalid_i;
  assign wreq1 = s1_awvalid_i | s1_wvalid_i;
  assign wg0   = w_q == W_GNT0;
  assign wg1   = w_q == W_GNT1;
  assign rg0   = r_q == R_GNT0;
  assign rg1   = r_q == R_GNT1;

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      w_q       <= W_IDLE;
      last_wr_q <= 1'b1;
    end else begin
      w_q       <= w_d;
      last_wr_q <= last_wr_d;
    end
  end

  // Master 0 takes a tie unless it was the last winner; the grant drops only after B completes.
  always_comb begin
    w_d       = w_q;
    last_wr_d = last_wr_q;
    if (w_q == W_IDLE) begin
      if (wreq0 & (~wreq1 | last_wr_q)) begin
        w_d       = W_GNT0;
        last_wr_d = 1'b0;
      end else if (wreq1) begin
        w_d       = W_GNT1;
        last_wr_d = 1'b1;
      end
    end else if (m_bvalid_i & m_bready_o) begin
      w_d = W_IDLE;
    end
  end

  always_comb begin
    m_awaddr_o   = wg0 ? s0_awaddr_i  : wg1 ? s1_awaddr_i  : '0;
    m_awvalid_o  = wg0 ? s0_awvalid_i : wg1 ? s1_awvalid_i : 1'b0;
    m_wdata_o    = wg0 ? s0_wdata_i   : wg1 ? s1_wdata_i   : '0;
    m_wstrb_o    = wg0 ? s0_wstrb_i   : wg1 ? s1_wstrb_i   : '0;
    m_wvalid_o   = wg0 ? s0_wvalid_i  : wg1 ? s1_wvalid_i  : 1'b0;
    m_bready_o   = wg0 ? s0_bready_i  : wg1 ? s1_bready_i  : 1'b0;
    s0_awready_o = wg0 & m_awready_i;
    s0_wready_o  = wg0 & m_wready_i;
    s0_bvalid_o  = wg0 & m_bvalid_i;
    s0_bresp_o   = wg0 ? m_bresp_i : 2'b00;
    s1_awready_o = wg1 & m_awready_i;
    s1_wready_o  = wg1 & m_wready_i;
    s1_bvalid_o  = wg1 & m_bvalid_i;
    s1_bresp_o   = wg1 ? m_bresp_i : 2'b00;
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      r_q       <= R_IDLE;
      last_rd_q <= 1'b1;
    end else begin
      r_q       <= r_d;
      last_rd_q <= last_rd_d;
    end
  end

  always_comb begin
    r_d       = r_q;
    last_rd_d = last_rd_q;
    if (r_q == R_IDLE) begin
      if (s0_arvalid_i & (~s1_arvalid_i | last_rd_q)) begin
        r_d       = R_GNT0;
        last_rd_d = 1'b0;
      end else if (s1_arvalid_i) begin
        r_d       = R_GNT1;
        last_rd_d = 1'b1;
      end
    end else if (m_rvalid_i & m_rready_o) begin
      r_d = R_IDLE;
    end
  end

  always_comb begin
    m_araddr_o   = rg0 ? s0_araddr_i  : rg1 ? s1_araddr_i  : '0;
    m_arvalid_o  = rg0 ? s0_arvalid_i : rg1 ? s1_arvalid_i : 1'b0;
    m_rready_o   = rg0 ? s0_rready_i  : rg1 ? s1_rready_i  : 1'b0;
    s0_arready_o = rg0 & m_arready_i;
    s0_rvalid_o  = rg0 & m_rvalid_i;
    s0_rresp_o   = rg0 ? m_rresp_i : 2'b00;
    s0_rdata_o   = rg0 ? m_rdata_i : '0;
    s1_arready_o = rg1 & m_arready_i;
    s1_rvalid_o  = rg1 & m_rvalid_i;
    s1_rresp_o   = rg1 ? m_rresp_i : 2'b00;
    s1_rdata_o   = rg1 ? m_rdata_i : '0;
  end
endmodule
